axi_master_wr_split: RTL and testbench

- Parametrised successor of the single-burst AXI4 write master. It accepts one user write of up to 65535 beats and splits it into AXI4 INCR bursts.
- Each burst is at most MAX_BURST beats and never crosses a 4 KB boundary.
- Data width and address width are configurable. Beats are pulled from a show-ahead write FIFO.
- Sits between axi_ctrl and the DDR AXI slave, in place of the fixed 64-bit write master.

---
 rtl/axi_master_wr_split.sv | 194 +++++++++++++++++++
 tb/tb_axi_master_wr_split.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_wr_split.sv
`default_nettype none
// ============================================================================
// Module   : axi_master_wr_split
// Brief    : Splits one user write into AXI4 INCR bursts of at most MAX_BURST
//            beats that never cross a 4 KB boundary. Beats are pulled from a
//            show-ahead FIFO. Define AXI_BRESP_CHECK_EN to add the sticky
//            wr_err output.
// Revision : 1.0 - initial release
// ============================================================================
module axi_master_wr_split #(
    parameter int         DATA_W    = 64,
    parameter int         ADDR_W    = 30,
    parameter int         MAX_BURST = 16,
    parameter logic [3:0] AXI_ID    = 4'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_start,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [15:0]           wr_beats,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_data_avail,
    output logic                  wr_data_rd,
    output logic                  wr_ready,
    output logic                  wr_done,
`ifdef AXI_BRESP_CHECK_EN
    output logic                  wr_err,
`endif
    output logic [3:0]            m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready
);

    localparam int c_SIZE = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_AW   = 3'd2,
        S_W    = 3'd3,
        S_B    = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_remaining;
    logic [8:0]          r_burst;
    logic [7:0]          r_beat_cnt;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [7:0]          r_awlen;
    logic                r_awvalid;
    logic                r_bready;
    logic                r_wr_done;

    logic [12:0]         w_beats_to_4k;
    logic [16:0]         w_burst;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_start_ok;
    logic                w_unused;

    // Burst length is the smallest of what is left, the burst cap and the room to the next 4 KB page.
    always_comb begin
        w_beats_to_4k = (13'h1000 - {1'b0, r_addr[11:0]}) >> c_SIZE;
        w_burst       = {1'b0, r_remaining};
        if (w_burst > 17'(MAX_BURST))
            w_burst = 17'(MAX_BURST);
        if (w_burst > {4'd0, w_beats_to_4k})
            w_burst = {4'd0, w_beats_to_4k};
    end

    assign w_w_hs     = m_axi_wvalid & m_axi_wready;
    assign w_b_hs     = m_axi_bvalid & r_bready;
    assign w_start_ok = (r_state == S_IDLE) && wr_start && (wr_beats != 16'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_burst     <= '0;
            r_beat_cnt  <= '0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_wr_done   <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_addr      <= {wr_addr[ADDR_W-1:c_SIZE], {c_SIZE{1'b0}}};
                        r_remaining <= wr_beats;
                        r_state     <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_awaddr  <= r_addr;
                    r_awlen   <= 8'(w_burst - 17'd1);
                    r_burst   <= w_burst[8:0];
                    r_awvalid <= 1'b1;
                    r_state   <= S_AW;
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        r_awvalid  <= 1'b0;
                        r_beat_cnt <= '0;
                        r_state    <= S_W;
                    end
                end
                S_W: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        if (r_beat_cnt == r_awlen) begin
                            r_remaining <= r_remaining - {7'd0, r_burst};
                            r_addr      <= r_addr + (ADDR_W'(r_burst) << c_SIZE);
                            r_bready    <= 1'b1;
                            r_state     <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        if (r_remaining == 16'd0) begin
                            r_wr_done <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state   <= S_CALC;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_BRESP_CHECK_EN
    logic r_wr_err;

    // Sticky error: cleared only when a new transfer is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wr_err <= 1'b0;
        else if (w_start_ok)
            r_wr_err <= 1'b0;
        else if (w_b_hs && (m_axi_bresp != 2'b00))
            r_wr_err <= 1'b1;
    end

    assign wr_err   = r_wr_err;
    assign w_unused = ^wr_addr[c_SIZE-1:0];
`else
    assign w_unused = ^{m_axi_bresp, wr_addr[c_SIZE-1:0]};
`endif

    assign wr_ready      = (r_state == S_IDLE);
    assign wr_done       = r_wr_done;
    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = 3'(c_SIZE);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0010;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (r_state == S_W) & wr_data_avail;
    assign m_axi_wlast   = (r_beat_cnt == r_awlen) & m_axi_wvalid;
    assign wr_data_rd    = w_w_hs;
    assign m_axi_bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_axi_master_wr_split.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_master_wr_split
// Brief    : Scoreboard bench: a burst-splitting reference model fills the
//            expected AW/W queues, a monitor pops and compares handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_master_wr_split;

    localparam int DATA_W    = 64;
    localparam int ADDR_W    = 30;
    localparam int MAX_BURST = 16;
    localparam int BYTES     = DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                wr_start;
    logic [ADDR_W-1:0]   wr_addr;
    logic [15:0]         wr_beats;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_data_avail;
    logic                wr_data_rd;
    logic                wr_ready;
    logic                wr_done;
`ifdef AXI_BRESP_CHECK_EN
    logic                wr_err;
`endif
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [BYTES-1:0]    wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    always #5 clk = ~clk;

    axi_master_wr_split #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST), .AXI_ID(4'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_start(wr_start), .wr_addr(wr_addr), .wr_beats(wr_beats),
        .wr_data(wr_data), .wr_data_avail(wr_data_avail), .wr_data_rd(wr_data_rd),
        .wr_ready(wr_ready), .wr_done(wr_done),
`ifdef AXI_BRESP_CHECK_EN
        .wr_err(wr_err),
`endif
        .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
        .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awqos(awqos),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [DATA_W-1:0] data; logic last; } w_t;

    aw_t               exp_aw[$];
    w_t                exp_w[$];
    logic [DATA_W-1:0] fifo_q[$];

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int aw_cnt = 0;
    int p_awready = 100;
    int p_wready = 100;
    int p_avail = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: walk the transfer page by page with plain arithmetic.
    task automatic model_push(input logic [ADDR_W-1:0] addr_in, input int beats);
        longint a;
        int     rem, to4k, n;
        aw_t    e;
        w_t     w;
        a   = longint'(addr_in) - (longint'(addr_in) % BYTES);
        rem = beats;
        while (rem > 0) begin
            to4k = int'((4096 - (a % 4096)) / BYTES);
            n = rem;
            if (n > MAX_BURST) n = MAX_BURST;
            if (n > to4k) n = to4k;
            e.addr = a[ADDR_W-1:0];
            e.len  = 8'(n - 1);
            exp_aw.push_back(e);
            for (int i = 0; i < n; i++) begin
                w.data = {$urandom, $urandom};
                w.last = (i == n - 1);
                exp_w.push_back(w);
                fifo_q.push_back(w.data);
            end
            rem -= n;
            a = (a + longint'(n) * BYTES) % (longint'(1) << ADDR_W);
        end
    endtask

    // Slave + FIFO model: sample settled handshakes at negedge, act after posedge.
    initial begin
        bit rs, do_pop, wl_hs, b_hs, pend_b;
        int bdelay;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        wr_data_avail = 1'b0; wr_data = '0; pend_b = 1'b0; bdelay = 0;
        forever begin
            @(negedge clk);
            rs     = rst_n;
            do_pop = wr_data_rd;
            wl_hs  = wvalid & wready & wlast;
            b_hs   = bvalid & bready;
            @(posedge clk);
            #1;
            if (!rs) begin
                fifo_q.delete();
                pend_b = 1'b0;
                bvalid = 1'b0;
            end else begin
                if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
                if (b_hs) bvalid = 1'b0;
                if (wl_hs) begin
                    pend_b = 1'b1;
                    bdelay = $urandom_range(0, 2);
                end
                if (pend_b) begin
                    if (bdelay == 0) begin
                        bvalid = 1'b1;
                        pend_b = 1'b0;
                    end else begin
                        bdelay--;
                    end
                end
            end
            awready       = ($urandom_range(1, 100) <= p_awready);
            wready        = ($urandom_range(1, 100) <= p_wready);
            wr_data_avail = (fifo_q.size() > 0) && ($urandom_range(1, 100) <= p_avail);
            wr_data       = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        end
    end

    // Monitor / scoreboard
    initial begin
        bit w_open, prev_b, prev_last, prev_stall;
        logic [ADDR_W-1:0] prev_addr;
        logic [7:0] prev_len;
        aw_t e;
        w_t  w;
        w_open = 0; prev_b = 0; prev_last = 0; prev_stall = 0;
        prev_addr = '0; prev_len = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_aw.delete();
                exp_w.delete();
                w_open = 0; prev_b = 0; prev_stall = 0;
                continue;
            end
            check("wr_done", wr_done, prev_b && prev_last);
            if (wr_done) done_cnt++;
            if (prev_stall) begin
                check("awvalid_held", awvalid, 1);
                check("awaddr_held", awaddr, prev_addr);
                check("awlen_held", awlen, prev_len);
            end
            check("wr_data_rd", wr_data_rd, wvalid & wready);
            if (!wvalid) check("wlast_idle", wlast, 0);
            if (wvalid && wready) begin
                check("w_after_aw", w_open, 1);
                if (exp_w.size() > 0) begin
                    w = exp_w.pop_front();
                    check("wdata", wdata, w.data);
                    check("wlast", wlast, w.last);
                    if (wlast) w_open = 0;
                end else begin
                    check("w_unexpected", exp_w.size(), 1);
                end
            end
            if (awvalid && awready) begin
                check("aw_expected", (exp_aw.size() != 0) && !w_open, 1);
                if (exp_aw.size() > 0) begin
                    e = exp_aw.pop_front();
                    check("awaddr", awaddr, e.addr);
                    check("awlen", awlen, e.len);
                end
                check("awsize", awsize, 3);
                check("awburst", awburst, 1);
                check("awid", awid, 0);
                check("awcache", awcache, 4'b0010);
                check("wstrb", wstrb, 8'hFF);
                w_open = 1;
                aw_cnt++;
            end
            prev_stall = awvalid && !awready;
            prev_addr  = awaddr;
            prev_len   = awlen;
            prev_b     = bvalid && bready;
            prev_last  = (exp_aw.size() == 0) && (exp_w.size() == 0);
        end
    end

    task automatic start_xfer(input logic [ADDR_W-1:0] a, input int beats);
        int n;
        n = 0;
        while (!wr_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_idle", wr_ready, 1);
        model_push(a, beats);
        @(posedge clk);
        #1;
        wr_start = 1'b1; wr_addr = a; wr_beats = beats[15:0];
        @(posedge clk);
        #1;
        wr_start = 1'b0;
        @(negedge clk);
        check("awvalid_lat1", awvalid, 0);
        check("wr_ready_busy", wr_ready, 0);
        @(negedge clk);
        check("awvalid_lat2", awvalid, 1);
    endtask

    task automatic run_xfer(input logic [ADDR_W-1:0] a, input int beats,
                            input int pa, input int pw, input int pv);
        int d0, n;
        p_awready = pa; p_wready = pw; p_avail = pv;
        d0 = done_cnt;
        start_xfer(a, beats);
        n = 0;
        while (done_cnt == d0 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("done_once", done_cnt - d0, 1);
        check("aw_drained", exp_aw.size(), 0);
        check("w_drained", exp_w.size(), 0);
    endtask

    initial begin
        int n, a0, beats;
        logic [ADDR_W-1:0] ra;
        rst_n = 1'b0; wr_start = 1'b0; wr_addr = '0; wr_beats = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);

        run_xfer(30'h0, 16, 100, 100, 100);
        run_xfer(30'hFC0, 16, 100, 100, 100);
        run_xfer(30'h0, 40, 100, 100, 100);
        run_xfer(30'h44, 8, 100, 50, 70);
        run_xfer(30'h3FFF_FFC0, 16, 70, 70, 70);

        // Zero-beat start must be ignored.
        @(posedge clk);
        #1 wr_start = 1'b1; wr_addr = 30'h100; wr_beats = 16'd0;
        @(posedge clk);
        #1 wr_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("zero_beats_idle", wr_ready, 1);
            check("zero_beats_noaw", awvalid, 0);
        end

        for (int i = 0; i < 14; i++) begin
            ra = 30'($urandom);
            if (i % 2 == 0) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
            beats = $urandom_range(1, 80);
            run_xfer(ra, beats, $urandom_range(30, 100), $urandom_range(30, 100),
                     $urandom_range(30, 100));
        end

        // Reset during W of burst 2 aborts the transfer.
        p_awready = 100; p_wready = 100; p_avail = 100;
        a0 = aw_cnt;
        start_xfer(30'h0, 40);
        n = 0;
        while (aw_cnt < a0 + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("second_aw_seen", aw_cnt >= a0 + 2, 1);
        repeat (3) @(negedge clk);
        check("mid_w_active", wvalid, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_awvalid", awvalid, 0);
        check("abort_wvalid", wvalid, 0);
        check("abort_bready", bready, 0);
        check("abort_wr_ready", wr_ready, 1);
        check("abort_awlen", awlen, 0);
        run_xfer(30'h200, 4, 100, 100, 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        fails++;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
